// File: rtl/rv32i_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32i_dmem_arbiter
//
// Shares one single-port data RAM between the core load/store port (c_*) and
// a debug/loader port (d_*). Each transaction takes two cycles on the RAM
// side. In ISSUE the winning request is presented to the RAM and the owner
// gets a gnt pulse. In RESP the 1-cycle-latency read data goes back to the
// owner with an rvalid pulse. Only one transaction is ever outstanding.
//
// Parameters
//   RAM_DEPTH : data memory size in bytes; word addresses at or above
//               RAM_DEPTH/4 are answered with err=1 and never reach the RAM
//   ADDR_W    : byte-address width of both requester ports
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   c_req/we/addr/wdata/wmask  core request; held stable until c_gnt
//   c_gnt, c_rvalid, c_rdata, c_err   core grant / response
//   d_*                      same set for the debug port
//   mem_en/we/addr/wdata/wmask  registered RAM request (wmask 0 on reads)
//   mem_rdata                RAM read data, valid the cycle after mem_en
//
// Build option
//   DMEM_ARB_RR_EN : when defined, ties go round-robin to the port that did
//                    not own the previous transaction. When undefined, the
//                    core port always wins ties.
// ---------------------------------------------------------------------------
module rv32i_dmem_arbiter #(
  parameter int RAM_DEPTH = 8192,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  input  logic [3:0]        c_wmask,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  output logic              c_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wmask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(RAM_DEPTH / 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Registered copy of the winning request; owner_d = 1 means debug port.
  logic              owner_d;
  logic              r_we;
  logic              r_oor;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wmask;

  logic              any_req;
  logic              arb_slot;
  logic              sel_d;
  logic              win_we;
  logic              win_oor;
  logic [ADDR_W-1:0] win_addr;
  logic [31:0]       win_wdata;
  logic [3:0]        win_wmask;
  logic [31:0]       resp_data;

  assign any_req  = c_req | d_req;
  // Requests are sampled only in IDLE and RESP, never in ISSUE.
  assign arb_slot = (state == IDLE) || (state == RESP);

`ifdef DMEM_ARB_RR_EN
  // Last-owner pointer. It resets to D so that the core wins the first tie.
  // It moves on every grant, so a waiting port is served in the next slot.
  logic last_d;

  always_ff @(posedge clk) begin
    if (rst)
      last_d <= 1'b1;
    else if (state == ISSUE)
      last_d <= owner_d;
  end

  assign sel_d = d_req & (~c_req | ~last_d);
`else
  // Fixed priority: the debug port wins only when the core is not asking.
  assign sel_d = d_req & ~c_req;
`endif

  assign win_we    = sel_d ? d_we    : c_we;
  assign win_addr  = sel_d ? d_addr  : c_addr;
  assign win_wdata = sel_d ? d_wdata : c_wdata;
  assign win_wmask = sel_d ? d_wmask : c_wmask;
  assign win_oor   = (win_addr[ADDR_W-1:2] >= WORD_LIMIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = any_req ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the arbitration winner. The out-of-range flag is decided here,
  // so the ISSUE cycle only needs a registered bit to suppress mem_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_d <= 1'b0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (arb_slot && any_req) begin
      owner_d <= sel_d;
      r_we    <= win_we;
      r_oor   <= win_oor;
      r_addr  <= win_addr;
      r_wdata <= win_wdata;
      r_wmask <= win_wmask;
    end
  end

  // Writes and out-of-range accesses return zero data.
  assign resp_data = (r_we | r_oor) ? 32'd0 : mem_rdata;

  // Output logic
  always_comb begin
    c_gnt     = 1'b0;
    c_rvalid  = 1'b0;
    c_rdata   = 32'd0;
    c_err     = 1'b0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    d_err     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    mem_wmask = 4'b0000;
    case (state)
      ISSUE: begin
        c_gnt = ~owner_d;
        d_gnt = owner_d;
        if (!r_oor) begin
          mem_en    = 1'b1;
          mem_we    = r_we;
          mem_addr  = r_addr;
          mem_wdata = r_wdata;
          mem_wmask = r_we ? r_wmask : 4'b0000;
        end
      end
      RESP: begin
        c_rvalid = ~owner_d;
        d_rvalid = owner_d;
        if (owner_d) begin
          d_rdata = resp_data;
          d_err   = r_oor;
        end else begin
          c_rdata = resp_data;
          c_err   = r_oor;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv32i_dmem_arbiter
//
// Drives rv32i_dmem_arbiter with directed and randomised requests. A small
// behavioural RAM sits on the mem_* port. A word-array memory model and a
// last-owner variable give the expected read data, err flags, grant owners
// and grant/response timing.
// ---------------------------------------------------------------------------
module tb_rv32i_dmem_arbiter;

  localparam int RAM_DEPTH = 8192;
  localparam int ADDR_W    = 32;
  localparam int WORDS     = RAM_DEPTH / 4;

  logic clk;
  logic rst;
  logic c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [3:0]  c_wmask;
  logic d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wmask;
  logic mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ram       [WORDS];
  logic [31:0] model_mem [WORDS];
  bit          model_last_d;

  rv32i_dmem_arbiter #(.RAM_DEPTH(RAM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wmask(c_wmask),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) ram[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[12:2]];
      end
    end
  end

  // The winner of a tie, as seen by the reference model.
  function automatic bit exp_tie_winner_d();
`ifdef DMEM_ARB_RR_EN
    return !model_last_d;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_oor(input logic [31:0] a);
    return (a / 4) >= WORDS;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return {19'd0, 11'($urandom_range(0, WORDS - 1)), 2'($urandom)};
  endfunction

  task automatic drive_port(input bit is_d, input logic req, input logic we,
                            input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
    if (is_d) begin
      d_req = req; d_we = we; d_addr = a; d_wdata = wd; d_wmask = wm;
    end else begin
      c_req = req; c_we = we; c_addr = a; c_wdata = wd; c_wmask = wm;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last_d = 1'b1;
  endtask

  // Runs one transaction on a single port. Only records what it observes.
  task automatic run_single(input bit is_d, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] wm,
                            output int gnt_cyc, output int rv_cyc,
                            output logic [31:0] rdata, output logic err, output bit mem_seen,
                            output logic [31:0] m_addr, output logic [31:0] m_wdata,
                            output logic [3:0] m_wmask, output logic m_we, output bit wrong_port);
    gnt_cyc = -1; rv_cyc = -1; rdata = '0; err = 1'b0; mem_seen = 1'b0;
    m_addr = '0; m_wdata = '0; m_wmask = '0; m_we = 1'b0; wrong_port = 1'b0;
    @(negedge clk);
    drive_port(is_d, 1'b1, we, a, wd, wm);
    for (int cyc = 1; cyc <= 10 && rv_cyc < 0; cyc++) begin
      @(negedge clk);
      if (mem_en) begin
        mem_seen = 1'b1; m_addr = mem_addr; m_wdata = mem_wdata; m_wmask = mem_wmask; m_we = mem_we;
      end
      if (is_d ? (c_gnt | c_rvalid) : (d_gnt | d_rvalid)) wrong_port = 1'b1;
      if ((is_d ? d_gnt : c_gnt) && gnt_cyc < 0) begin
        gnt_cyc = cyc;
        drive_port(is_d, 1'b0, we, a, wd, wm);
      end
      if (is_d ? d_rvalid : c_rvalid) begin
        rv_cyc = cyc;
        rdata  = is_d ? d_rdata : c_rdata;
        err    = is_d ? d_err : c_err;
      end
    end
    drive_port(is_d, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_port(1'b0, 1'b1, 1'b1, rand_addr(), $urandom, 4'hF);
    drive_port(1'b1, 1'b1, 1'b0, rand_addr(), $urandom, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({c_gnt, c_rvalid, c_rdata, c_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wmask} !== '0) begin
        failures++;
        $display("[TB] FAIL reset_outputs cycle %0d: c_gnt=%b d_gnt=%b mem_en=%b c_rvalid=%b d_rvalid=%b, expected all 0",
                 i, c_gnt, d_gnt, mem_en, c_rvalid, d_rvalid);
      end
    end
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    rst = 1'b0;
    model_last_d = 1'b1;
  endtask

  task automatic test_write_read();
    int g, r; logic [31:0] rd, ma, mw; logic e, mwe; logic [3:0] mm; bit seen, wp;
    run_single(1'b0, 1'b1, 32'h1000, 32'h12345678, 4'b1111, g, r, rd, e, seen, ma, mw, mm, mwe, wp);
    model_mem[32'h1000 >> 2] = 32'h12345678;
    model_last_d = 1'b0;
    checks++; if (g !== 1) begin failures++; $display("[TB] FAIL wr_gnt_latency got %0d expected 1", g); end
    checks++; if (!seen || mwe !== 1'b1 || mm !== 4'b1111) begin failures++;
      $display("[TB] FAIL wr_mem_strobe got en=%b we=%b mask=%b expected 1 1 1111", seen, mwe, mm); end
    checks++; if (ma[31:2] !== 30'h400 || mw !== 32'h12345678) begin failures++;
      $display("[TB] FAIL wr_mem_fields got addr=%h data=%h expected 1000 12345678", ma, mw); end
    checks++; if (r !== 2 || rd !== 32'd0 || e !== 1'b0 || wp) begin failures++;
      $display("[TB] FAIL wr_resp got rv=%0d rdata=%h err=%b wrongport=%b expected 2 0 0 0", r, rd, e, wp); end
    run_single(1'b0, 1'b0, 32'h1000, 32'hDEADBEEF, 4'b1111, g, r, rd, e, seen, ma, mw, mm, mwe, wp);
    checks++; if (g !== 1 || r !== 2) begin failures++;
      $display("[TB] FAIL rd_latency got gnt=%0d rv=%0d expected 1 2", g, r); end
    checks++; if (!seen || mwe !== 1'b0 || mm !== 4'b0000) begin failures++;
      $display("[TB] FAIL rd_mem_strobe got en=%b we=%b mask=%b expected 1 0 0000", seen, mwe, mm); end
    checks++; if (rd !== 32'h12345678 || e !== 1'b0) begin failures++;
      $display("[TB] FAIL rd_data got %h err=%b expected 12345678 0", rd, e); end
  endtask

  task automatic test_arbitration();
    bit pend, pend_d, exp_d;
    logic [31:0] pend_data, ca, da;
    int grants, c_cnt, d_cnt, last_gnt;
    reset_dut();
    pend = 0; pend_d = 0; pend_data = '0; grants = 0; c_cnt = 0; d_cnt = 0; last_gnt = -1;
    ca = rand_addr(); da = rand_addr();
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b0, ca, 32'd0, 4'd0);
    drive_port(1'b1, 1'b1, 1'b0, da, 32'd0, 4'd0);
    for (int cyc = 1; cyc <= 40 && (grants < 8 || pend); cyc++) begin
      @(negedge clk);
      checks++;
      if (pend) begin
        if ((pend_d ? d_rvalid : c_rvalid) !== 1'b1 || (pend_d ? c_rvalid : d_rvalid) !== 1'b0 ||
            (pend_d ? d_rdata : c_rdata) !== pend_data) begin
          failures++;
          $display("[TB] FAIL arb_resp got c_rv=%b d_rv=%b c_rd=%h d_rd=%h expected owner_d=%b data=%h",
                   c_rvalid, d_rvalid, c_rdata, d_rdata, pend_d, pend_data);
        end
        pend = 0;
      end else if (c_rvalid | d_rvalid) begin
        failures++;
        $display("[TB] FAIL arb_spurious_rvalid got c=%b d=%b expected 0 0", c_rvalid, d_rvalid);
      end
      if (c_gnt | d_gnt) begin
        exp_d = exp_tie_winner_d();
        checks++;
        if (c_gnt !== !exp_d || d_gnt !== exp_d) begin
          failures++;
          $display("[TB] FAIL arb_winner grant %0d got c=%b d=%b expected d=%b", grants, c_gnt, d_gnt, exp_d);
        end
        if (last_gnt >= 0) begin
          checks++;
          if (cyc - last_gnt != 2) begin failures++;
            $display("[TB] FAIL arb_spacing got %0d expected 2", cyc - last_gnt); end
        end
        last_gnt = cyc;
        model_last_d = d_gnt;
        pend = 1; pend_d = d_gnt;
        pend_data = model_mem[d_gnt ? da[12:2] : ca[12:2]];
        if (d_gnt) d_cnt++; else c_cnt++;
        grants++;
        if (grants == 8) begin
          drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
          drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        end else if (d_gnt) begin
          da = rand_addr(); drive_port(1'b1, 1'b1, 1'b0, da, 32'd0, 4'd0);
        end else begin
          ca = rand_addr(); drive_port(1'b0, 1'b1, 1'b0, ca, 32'd0, 4'd0);
        end
      end
    end
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    checks++;
`ifdef DMEM_ARB_RR_EN
    if (grants != 8 || pend || c_cnt != 4 || d_cnt != 4) begin failures++;
      $display("[TB] FAIL arb_totals got grants=%0d c=%0d d=%0d pend=%b expected 8 4 4 0", grants, c_cnt, d_cnt, pend); end
`else
    if (grants != 8 || pend || c_cnt != 8 || d_cnt != 0) begin failures++;
      $display("[TB] FAIL arb_totals got grants=%0d c=%0d d=%0d pend=%b expected 8 8 0 0", grants, c_cnt, d_cnt, pend); end
`endif
  endtask

  task automatic test_out_of_range();
    int g, r; logic [31:0] rd, ma, mw; logic e, mwe; logic [3:0] mm; bit seen, wp;
    run_single(1'b1, 1'b0, 32'h2000, 32'd0, 4'd0, g, r, rd, e, seen, ma, mw, mm, mwe, wp);
    model_last_d = 1'b1;
    checks++; if (g !== 1 || r !== 2 || wp) begin failures++;
      $display("[TB] FAIL oor_rd_timing got gnt=%0d rv=%0d wrongport=%b expected 1 2 0", g, r, wp); end
    checks++; if (seen || e !== 1'b1 || rd !== 32'd0) begin failures++;
      $display("[TB] FAIL oor_rd_resp got mem_en=%b err=%b rdata=%h expected 0 1 0", seen, e, rd); end
    run_single(1'b1, 1'b1, 32'hFFFF_FFF0, $urandom, 4'hF, g, r, rd, e, seen, ma, mw, mm, mwe, wp);
    checks++; if (g !== 1 || r !== 2 || seen || e !== 1'b1 || rd !== 32'd0) begin failures++;
      $display("[TB] FAIL oor_wr got gnt=%0d rv=%0d mem_en=%b err=%b rdata=%h expected 1 2 0 1 0", g, r, seen, e, rd); end
    run_single(1'b1, 1'b0, 32'h1FFC, 32'd0, 4'd0, g, r, rd, e, seen, ma, mw, mm, mwe, wp);
    checks++; if (!seen || e !== 1'b0 || rd !== model_mem[WORDS-1]) begin failures++;
      $display("[TB] FAIL top_word_rd got mem_en=%b err=%b rdata=%h expected 1 0 %h", seen, e, rd, model_mem[WORDS-1]); end
  endtask

  task automatic test_back_to_back();
    int g1, r1, g2, r2;
    logic [31:0] a1, a2, w2, rd1, rd2;
    g1 = -1; r1 = -1; g2 = -1; r2 = -1; rd1 = '0; rd2 = '0;
    a1 = rand_addr(); a2 = rand_addr(); w2 = $urandom;
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b0, a1, 32'd0, 4'd0);
    for (int cyc = 1; cyc <= 12 && r2 < 0; cyc++) begin
      @(negedge clk);
      if (c_gnt) begin
        if (g1 < 0) g1 = cyc; else if (g2 < 0) g2 = cyc;
        c_req = 1'b0;
      end
      if (c_rvalid) begin
        if (r1 < 0) begin
          r1 = cyc; rd1 = c_rdata;
          drive_port(1'b0, 1'b1, 1'b1, a2, w2, 4'hF);
        end else begin
          r2 = cyc; rd2 = c_rdata;
        end
      end
    end
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    checks++; if (g1 != 1 || r1 != 2 || rd1 !== model_mem[a1[12:2]]) begin failures++;
      $display("[TB] FAIL b2b_first got gnt=%0d rv=%0d rdata=%h expected 1 2 %h", g1, r1, rd1, model_mem[a1[12:2]]); end
    checks++; if (g2 != r1 + 1 || r2 != g2 + 1 || rd2 !== 32'd0) begin failures++;
      $display("[TB] FAIL b2b_second got gnt=%0d rv=%0d rdata=%h expected %0d %0d 0", g2, r2, rd2, r1 + 1, r1 + 2); end
    model_mem[a2[12:2]] = w2;
    model_last_d = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int g, r, gd; logic [31:0] rd, ma, mw, a; logic e, mwe; logic [3:0] mm; bit seen, wp, stray;
    reset_dut();
    gd = -1; stray = 0;
    @(negedge clk);
    drive_port(1'b1, 1'b1, 1'b0, rand_addr(), 32'd0, 4'd0);
    for (int cyc = 1; cyc <= 5 && gd < 0; cyc++) begin
      @(negedge clk);
      if (d_gnt) begin
        gd = cyc; rst = 1'b1;
        drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      end
    end
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    checks++; if (gd != 1) begin failures++; $display("[TB] FAIL rst_mid_gnt got %0d expected 1", gd); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0;
      if (c_rvalid | d_rvalid | c_gnt | d_gnt | mem_en) stray = 1'b1;
    end
    model_last_d = 1'b1;
    checks++; if (stray) begin failures++; $display("[TB] FAIL rst_mid_no_resp got activity=1 expected 0"); end
    a = rand_addr();
    run_single(1'b0, 1'b0, a, 32'd0, 4'd0, g, r, rd, e, seen, ma, mw, mm, mwe, wp);
    model_last_d = 1'b0;
    checks++; if (g !== 1 || r !== 2 || rd !== model_mem[a[12:2]] || wp) begin failures++;
      $display("[TB] FAIL rst_mid_next got gnt=%0d rv=%0d rdata=%h expected 1 2 %h", g, r, rd, model_mem[a[12:2]]); end
  endtask

  task automatic test_random();
    int g, r; logic [31:0] rd, ma, mw, a, wd, exp_rd; logic e, mwe, we; logic [3:0] mm, wm;
    bit seen, wp, is_d, oor;
    for (int i = 0; i < 24; i++) begin
      is_d = 1'($urandom); we = 1'($urandom); wd = $urandom; wm = 4'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? (32'h2000 + {$urandom_range(0, 4095), 2'b00}) : rand_addr();
      oor = model_oor(a);
      exp_rd = (we || oor) ? 32'd0 : model_mem[a[12:2]];
      run_single(is_d, we, a, wd, wm, g, r, rd, e, seen, ma, mw, mm, mwe, wp);
      checks++;
      if (g !== 1 || r !== 2 || wp || rd !== exp_rd || e !== oor || seen !== !oor ||
          (!oor && (ma[31:2] !== a[31:2] || mwe !== we || mm !== (we ? wm : 4'b0000)))) begin
        failures++;
        $display("[TB] FAIL random_txn %0d port_d=%b we=%b addr=%h got gnt=%0d rv=%0d rdata=%h err=%b mem_en=%b mask=%b expected 1 2 %h %b %b %b",
                 i, is_d, we, a, g, r, rd, e, seen, mm, exp_rd, oor, !oor, we ? wm : 4'b0000);
      end
      if (we && !oor) model_mem[a[12:2]] = merge(model_mem[a[12:2]], wd, wm);
      model_last_d = is_d;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    model_last_d = 1'b1;
    mem_rdata = 32'd0;
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    for (int i = 0; i < WORDS; i++) begin
      ram[i] = $urandom;
      model_mem[i] = ram[i];
    end
    test_reset();
    test_write_read();
    test_arbitration();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
